// File: rtl/pulse_gen_prog.sv
// ---------------------------------------------------------------------------
// pulse_gen_prog
//
// Programmable tick generator with two modes:
//   - periodic: a one-cycle pulse every period_reg+1 enabled cycles
//   - one-shot: a single pulse period_reg+2 cycles after start, busy while
//     the shot is in flight
// The terminal count (period_reg) is loadable at runtime.
//
// Optional build macro:
//   PULSE_GEN_RETRIGGER_EN - when defined, start while busy restarts the
//                            one-shot interval (retriggerable timeout).
//                            When undefined, start while busy is ignored.
//
// Ports:
//   clk     in   system clock, all logic on posedge
//   rst     in   synchronous reset, active-high, overrides all inputs
//   en      in   count enable; low holds the counter and state
//   mode    in   0 = periodic, 1 = one-shot
//   start   in   one-shot trigger strobe (ignored in periodic mode)
//   load    in   period load strobe
//   period  in   new terminal count, sampled when load=1
//   pulse   out  registered tick, one cycle wide
//   busy    out  one-shot in progress
//   count   out  current counter value
// ---------------------------------------------------------------------------
module pulse_gen_prog #(
  parameter int unsigned           CNT_W          = 24,
  parameter logic [CNT_W-1:0]      DEFAULT_PERIOD = 24'd12_499_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  output logic             pulse,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pulse_q,  pulse_d;
  logic             busy_q,   busy_d;
  // Previous value of the mode input, used to detect a mode change.
  logic             mode_q;

  logic mode_chg;
  logic terminal;
  logic retrig;

  assign mode_chg = (mode != mode_q);
  assign terminal = (cnt_q == period_q);

`ifdef PULSE_GEN_RETRIGGER_EN
  assign retrig = mode & start;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pulse_d  = 1'b0;

    if (load) begin
      // Load always restarts the count and suppresses any tick this cycle.
      period_d = period;
      cnt_d    = '0;
      if (state_q == RUN && mode_chg) begin
        state_d = IDLE;
      end else if (state_q == IDLE && mode && start && en) begin
        // Load + start together launch the shot with the new period.
        state_d = RUN;
      end
    end else if (state_q == RUN && mode_chg) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && (!mode || start)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (retrig) begin
            // Aborted interval: restart from zero, no pulse.
            cnt_d = '0;
          end else if (en) begin
            if (terminal) begin
              cnt_d   = '0;
              pulse_d = 1'b1;
              if (mode) begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // busy is only meaningful for a one-shot; it drops with the pulse
    // because the terminal count moves the state back to IDLE.
    busy_d = (state_d == RUN) && mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= DEFAULT_PERIOD;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      // Track mode during reset so leaving reset is not seen as a change.
      mode_q   <= mode;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      mode_q   <= mode;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_pulse_gen_prog.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_prog
//
// Self-checking bench for pulse_gen_prog with CNT_W=8, DEFAULT_PERIOD=6.
// A table of per-cycle vectors covers periodic counting, enable hold, load at
// terminal count, mode change and load+start one-shot; hand-written
// sequences cover reset mid-operation, one-shot hold, retrigger and period 0.
// ---------------------------------------------------------------------------
module tb_pulse_gen_prog;

  localparam int unsigned      CNT_W = 8;
  localparam logic [CNT_W-1:0] DEF_P = 8'd6;

  logic             clk;
  logic             rst;
  logic             en;
  logic             mode;
  logic             start;
  logic             load;
  logic [CNT_W-1:0] period;
  logic             pulse;
  logic             busy;
  logic [CNT_W-1:0] count;

  pulse_gen_prog #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEF_P)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .start  (start),
    .load   (load),
    .period (period),
    .pulse  (pulse),
    .busy   (busy),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic             en;
    logic             mode;
    logic             start;
    logic             load;
    logic [CNT_W-1:0] per;
    logic             ep;
    logic             eb;
    logic [CNT_W-1:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic e, input logic m, input logic s,
                     input logic l, input int p, input logic ep, input logic eb,
                     input int ec);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.start = s; v.load = l;
    v.per = p[CNT_W-1:0]; v.ep = ep; v.eb = eb; v.ec = ec[CNT_W-1:0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock with current inputs until pulse is seen; edges numbered from
  // first_edge. Returns -1 if limit is exceeded.
  task automatic wait_pulse(input int first_edge, input int limit, output int at);
    at = -1;
    for (int e = first_edge; e <= limit; e++) begin
      tick();
      if (pulse) begin
        at = e;
        return;
      end
    end
  endtask

  initial begin
    int at;
    int npulse;
    int first;
    int bad;

    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; load = 1'b0; period = '0;

    // ---------------- vector table ----------------
    //   rst en md st ld per   pulse busy count
    add(1, 0, 0, 0, 0, 0,    0, 0, 0);   // reset
    add(0, 0, 0, 0, 1, 4,    0, 0, 0);   // load 4 while idle
    add(0, 1, 0, 0, 0, 0,    0, 0, 0);   // enter RUN
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 0, 0, 0, 0, k);
    add(0, 1, 0, 0, 0, 0,    1, 0, 0);   // tick
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 0, 0, 0, 0, k);
    add(0, 1, 0, 0, 0, 0,    1, 0, 0);   // tick every 5 cycles
    add(0, 1, 0, 0, 0, 0,    0, 0, 1);
    add(0, 1, 0, 0, 0, 0,    0, 0, 2);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 2); // en low holds
    add(0, 1, 0, 0, 0, 0,    0, 0, 3);
    add(0, 1, 0, 0, 0, 0,    0, 0, 4);
    add(0, 1, 0, 0, 0, 0,    1, 0, 0);   // pulse 3 cycles after en returns
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 0, 0, 0, 0, k);
    add(0, 1, 0, 0, 1, 9,    0, 0, 0);   // load at terminal: no tick
    for (int k = 1; k <= 9; k++) add(0, 1, 0, 0, 0, 0, 0, 0, k);
    add(0, 1, 0, 0, 0, 0,    1, 0, 0);   // 11 cycles after load
    add(0, 1, 1, 0, 0, 0,    0, 0, 0);   // mode change -> IDLE
    add(0, 1, 1, 1, 1, 3,    0, 1, 0);   // load 3 + start one-shot
    add(0, 1, 1, 0, 0, 0,    0, 1, 1);
    add(0, 1, 1, 0, 0, 0,    0, 1, 2);
    add(0, 1, 1, 0, 0, 0,    0, 1, 3);
    add(0, 1, 1, 0, 0, 0,    1, 0, 0);   // pulse, busy drops
    add(0, 1, 1, 0, 0, 0,    0, 0, 0);   // no further pulses
    add(0, 1, 1, 0, 0, 0,    0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      start = vecs[i].start; load = vecs[i].load; period = vecs[i].per;
      tick();
      chk($sformatf("row%0d pulse", i), int'(pulse), int'(vecs[i].ep));
      chk($sformatf("row%0d busy", i),  int'(busy),  int'(vecs[i].eb));
      chk($sformatf("row%0d count", i), int'(count), int'(vecs[i].ec));
      $display("row %0d: rst=%0b en=%0b mode=%0b start=%0b load=%0b per=%0d -> pulse=%0b busy=%0b count=%0d",
               i, rst, en, mode, start, load, period, pulse, busy, count);
    end
    rst = 0; en = 1; mode = 1; start = 0; load = 0; period = '0;

    // ---------------- reset mid-periodic ----------------
    mode = 0;
    tick();                               // IDLE -> RUN (periodic, period 3)
    tick(); tick(); tick();               // count 3
    chk("pre_rst_periodic count", int'(count), 3);
    rst = 1; load = 1; period = 8'd2;     // rst overrides load
    tick();
    chk("rst_periodic pulse", int'(pulse), 0);
    chk("rst_periodic busy",  int'(busy),  0);
    chk("rst_periodic count", int'(count), 0);
    rst = 0; load = 0;
    wait_pulse(1, 40, at);
    chk("default period first latency", at, int'(DEF_P) + 2);
    wait_pulse(1, 40, at);
    chk("default period interval", at, int'(DEF_P) + 1);
    $display("reset mid-periodic: default period latency checked, last at=%0d", at);

    // ---------------- reset mid-one-shot ----------------
    mode = 1;
    tick();                               // mode change -> IDLE
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    chk("oneshot pre_rst busy",  int'(busy),  1);
    chk("oneshot pre_rst count", int'(count), 3);
    rst = 1; tick(); rst = 0;
    chk("rst_oneshot pulse", int'(pulse), 0);
    chk("rst_oneshot busy",  int'(busy),  0);
    chk("rst_oneshot count", int'(count), 0);
    start = 1; tick(); start = 0;
    chk("oneshot busy after start", int'(busy), 1);
    wait_pulse(2, 40, at);
    chk("oneshot latency default", at, int'(DEF_P) + 2);
    chk("oneshot busy at pulse", int'(busy), 0);
    $display("reset mid-one-shot: latency=%0d", at);

    // ---------------- one-shot holds with en low ----------------
    start = 1; tick(); start = 0;
    tick(); tick();
    en = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pulse || !busy || count != 8'd2) bad++;
    end
    chk("oneshot en-low hold violations", bad, 0);
    en = 1;
    wait_pulse(1, 20, at);
    chk("oneshot resume latency", at, 5);
    $display("one-shot en hold: violations=%0d resume latency=%0d", bad, at);

    // ---------------- second start during one-shot ----------------
    load = 1; period = 8'd5; tick(); load = 0;
    npulse = 0; first = -1;
    for (int e = 1; e <= 20; e++) begin
      start = (e == 1 || e == 4);
      tick();
      if (pulse) begin
        npulse++;
        if (first < 0) first = e;
      end
    end
    start = 0;
`ifdef PULSE_GEN_RETRIGGER_EN
    chk("retrigger pulse edge", first, 10);
`else
    chk("second start ignored pulse edge", first, 7);
`endif
    chk("second start pulse count", npulse, 1);
    $display("second start: first pulse at edge %0d, pulses=%0d", first, npulse);

    // ---------------- period 0 ----------------
    load = 1; period = 8'd0; mode = 0; en = 0; tick(); load = 0;
    en = 1; tick();
    chk("p0 enter run pulse", int'(pulse), 0);
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (pulse) npulse++;
    end
    chk("p0 periodic continuous pulses", npulse, 6);
    mode = 1; tick();
    chk("p0 mode change pulse", int'(pulse), 0);
    chk("p0 mode change busy",  int'(busy),  0);
    start = 1; tick(); start = 0;
    chk("p0 oneshot busy", int'(busy), 1);
    tick();
    chk("p0 oneshot pulse", int'(pulse), 1);
    chk("p0 oneshot busy end", int'(busy), 0);
    $display("period 0: periodic pulses=%0d of 6", npulse);

    // ---------------- mode change mid count ----------------
    load = 1; period = 8'd9; tick(); load = 0;
    mode = 0; tick();                     // enter periodic RUN
    start = 1;                            // ignored in periodic
    tick(); tick(); tick(); tick();
    start = 0;
    chk("periodic start ignored busy", int'(busy), 0);
    chk("mid count value", int'(count), 4);
    mode = 1; tick();
    chk("mode change count", int'(count), 0);
    chk("mode change pulse", int'(pulse), 0);
    mode = 0; tick(); tick();
    chk("periodic re-entry count", int'(count), 1);
    $display("mode change mid count: count after re-entry=%0d", count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_gen_prog.md
Name: pulse_gen_prog

Overview:
Programmable periodic/one-shot tick generator. Successor to the fixed free-running 2^24 divider: runtime-loadable period, enable/hold, and a one-shot mode with busy flag. Sits beside the lock FSM and debouncers to supply debounce strobes, display-refresh ticks and lockout/timeout one-shots from the system clock.

Parameters:
CNT_W, 24, counter and period width in bits
DEFAULT_PERIOD, 24'd12_499_999, period register value after reset (terminal count; tick every DEFAULT_PERIOD+1 cycles)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; low = counter holds
mode  input  1  0 = periodic, 1 = one-shot
start  input  1  one-shot trigger, single-cycle strobe, ignored in periodic mode
load  input  1  period load strobe
period  input  CNT_W  new terminal count, sampled when load=1
pulse  output  1  registered tick, exactly 1 cycle wide
busy  output  1  one-shot in progress
count  output  CNT_W  current counter value, for debug/display

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. All outputs registered.
- Reset (rst=1 at posedge): counter=0, period_reg=DEFAULT_PERIOD, pulse=0, busy=0, state=IDLE. rst overrides every other input.
- FSM states: IDLE, RUN.
  - IDLE -> RUN: mode=0 and en=1, or mode=1 and start=1 and en=1.
  - RUN -> IDLE: one-shot terminal count reached; mode input changes; en=0 in one-shot mode does NOT leave RUN (it holds).
- Counting in RUN with en=1: counter increments by 1. At counter==period_reg, counter<=0, and pulse=1 the following cycle.
  - Periodic: ticks repeat every period_reg+1 cycles.
  - One-shot: single tick; busy drops in the same cycle pulse rises. Start-to-pulse latency is period_reg+2 cycles.
- en=0: counter holds value, pulse=0, state unchanged. Periodic mode with en=0 from IDLE stays IDLE.
- period_reg=0: periodic mode gives pulse=1 every cycle while en=1; one-shot gives pulse 2 cycles after start.
- load=1: period_reg<=period, counter<=0, pulse=0 that cycle, state unchanged (a running one-shot restarts its count). If load and the terminal count coincide, load wins and no tick is emitted.
- Mode change while RUN: counter<=0, go to IDLE, pulse=0, busy=0. Periodic mode re-enters RUN on the next cycle if en=1.
- start while busy: ignored, unless RETRIGGER_EN is defined.
- start and load in the same cycle from IDLE in one-shot mode: the new period is loaded and the one-shot starts with it; latency is period+2.
- Width: counter compare is unsigned CNT_W bits. The counter never exceeds period_reg, so there is no wrap-around past 2^CNT_W-1.
- busy=1 only in one-shot mode while in RUN; it is always 0 in periodic mode.

Optional Feature:
PULSE_GEN_RETRIGGER_EN
- Defined: start while busy (one-shot) resets counter to 0 and stays in RUN. No pulse is emitted for the aborted interval, so a retriggerable timeout fires period_reg+2 cycles after the last start.
- Undefined: start while busy is ignored; the original one-shot completes on schedule.

Test Plan:
- Reset, periodic, CNT_W=8, load period=4, en=1 -> pulse high 1 cycle, repeating every 5 cycles; count sequence 0,1,2,3,4,0.
- One-shot, period_reg=3, start at cycle T -> busy=1 from T+1; single pulse at T+5; busy=0 at T+5; no further pulses.
- en dropped for 10 cycles mid-period at count=2, period 4 -> count holds at 2, no pulse; after en returns, pulse 3 cycles later.
- load period=9 asserted in the cycle count==period_reg -> no tick; count=0 next cycle; next pulse 11 cycles after the load.
- One-shot period 5, second start 3 cycles after the first -> without the macro, pulse at first start+7; with PULSE_GEN_RETRIGGER_EN, pulse at second start+7 only.
- rst asserted mid-one-shot and mid-periodic -> next cycle pulse=0, busy=0, count=0, period_reg=DEFAULT_PERIOD; period_reg=0 periodic yields continuous pulse=1.
